// File: rtl/branch_recovery_controller.sv
// Branch resolution and recovery sequencer: redirects fetch on a mispredict,
// trains the pattern table and BTB, and buffers one branch that arrives while busy.
module branch_recovery_controller #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             Branch_EX,
   input  logic             branchTaken,
   input  logic             prediction_EX,
   input  logic [31:0]      predicted_target_EX,
   input  logic [31:0]      branch_target_EX,
   input  logic [31:0]      PC_EX,
   input  logic [4:0]       GHR_in,
   input  logic [4:0]       GHPT_index_in,
   input  logic [4:0]       G_BTB_index_in,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_PC,
   output logic             ghr_restore_valid,
   output logic [4:0]       ghr_restore,
   output logic             pht_we,
   output logic [4:0]       pht_index,
   output logic             pht_taken,
   output logic             btb_we,
   output logic [4:0]       btb_index,
   output logic [31:0]      btb_target,
   output logic             stall_fetch,
   output logic             busy,
   output logic             overflow,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   typedef enum logic [1:0] {IDLE, RECOVER, UPD_PHT, UPD_BTB} state_t;

   typedef struct packed {
      logic        taken;
      logic        mispred;
      logic [31:0] pc;
      logic [31:0] target;
      logic [4:0]  ghr;
      logic [4:0]  pht_idx;
      logic [4:0]  btb_idx;
   } op_t;

   state_t state;
   op_t    cur;
   op_t    pend;
   logic   pend_valid;
   op_t    in_op;
   op_t    start_op;
   logic   accept;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   always_comb begin
      in_op         = '0;
      in_op.taken   = branchTaken;
      in_op.mispred = (prediction_EX != branchTaken) ||
                      (branchTaken && (predicted_target_EX != branch_target_EX));
      in_op.pc      = PC_EX;
      in_op.target  = branch_target_EX;
      in_op.ghr     = GHR_in;
      in_op.pht_idx = GHPT_index_in;
      in_op.btb_idx = G_BTB_index_in;
      // a buffered branch is older than the one in EX, so it goes first
      start_op      = pend_valid ? pend : in_op;
      accept        = Branch_EX && ((state == IDLE) ||
                      (((state == UPD_PHT) || (state == UPD_BTB)) && !pend_valid));
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state             <= IDLE;
         cur               <= '0;
         pend              <= '0;
         pend_valid        <= 1'b0;
         flush             <= 1'b0;
         redirect_valid    <= 1'b0;
         redirect_PC       <= '0;
         ghr_restore_valid <= 1'b0;
         ghr_restore       <= '0;
         pht_we            <= 1'b0;
         pht_index         <= '0;
         pht_taken         <= 1'b0;
         btb_we            <= 1'b0;
         btb_index         <= '0;
         btb_target        <= '0;
         stall_fetch       <= 1'b0;
         busy              <= 1'b0;
         overflow          <= 1'b0;
         branch_count      <= '0;
         mispredict_count  <= '0;
      end else begin
         flush             <= 1'b0;
         redirect_valid    <= 1'b0;
         ghr_restore_valid <= 1'b0;
         pht_we            <= 1'b0;
         btb_we            <= 1'b0;

         if (accept)
            branch_count <= sat_inc(branch_count);

         case (state)
            IDLE: begin
               if (pend_valid) begin
                  pend_valid <= Branch_EX;
                  pend       <= in_op;
               end
               if (pend_valid || Branch_EX) begin
                  cur  <= start_op;
                  busy <= 1'b1;
                  if (start_op.mispred) begin
                     state             <= RECOVER;
                     flush             <= 1'b1;
                     redirect_valid    <= 1'b1;
                     ghr_restore_valid <= 1'b1;
                     redirect_PC       <= start_op.taken ? start_op.target : start_op.pc + 32'd4;
                     ghr_restore       <= {start_op.ghr[3:0], start_op.taken};
                     stall_fetch       <= 1'b0;
                     mispredict_count  <= sat_inc(mispredict_count);
                  end else begin
                     state       <= UPD_PHT;
                     pht_we      <= 1'b1;
                     pht_index   <= start_op.pht_idx;
                     pht_taken   <= start_op.taken;
                     stall_fetch <= 1'b1;
                  end
               end
            end

            RECOVER: begin
               // anything buffered or arriving now is on the wrong path
               pend_valid  <= 1'b0;
               state       <= UPD_PHT;
               pht_we      <= 1'b1;
               pht_index   <= cur.pht_idx;
               pht_taken   <= cur.taken;
               stall_fetch <= 1'b1;
            end

            UPD_PHT: begin
               if (cur.taken) begin
                  state       <= UPD_BTB;
                  btb_we      <= 1'b1;
                  btb_index   <= cur.btb_idx;
                  btb_target  <= cur.target;
                  stall_fetch <= 1'b1;
               end else begin
                  state       <= IDLE;
                  stall_fetch <= 1'b0;
                  busy        <= 1'b0;
               end
            end

            UPD_BTB: begin
               state       <= IDLE;
               stall_fetch <= 1'b0;
               busy        <= 1'b0;
            end

            default: begin
               state       <= IDLE;
               stall_fetch <= 1'b0;
               busy        <= 1'b0;
            end
         endcase

         if (Branch_EX && ((state == UPD_PHT) || (state == UPD_BTB))) begin
            if (pend_valid) begin
               overflow <= 1'b1;
            end else begin
               pend       <= in_op;
               pend_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_recovery_controller.sv
// Directed vector bench for branch_recovery_controller, with hand sequences
// for counter saturation and reset in the middle of a training sequence.
module tb_branch_recovery_controller;

   localparam int unsigned CW = 3;

   typedef struct packed {
      logic        br;
      logic        taken;
      logic        pred;
      logic [31:0] ptgt;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic [4:0]  ghr;
      logic [4:0]  pi;
      logic [4:0]  bi;
   } in_t;

   typedef struct packed {
      logic          flush;
      logic          rv;
      logic [31:0]   rpc;
      logic          grv;
      logic [4:0]    gr;
      logic          pwe;
      logic [4:0]    pidx;
      logic          pt;
      logic          bwe;
      logic [4:0]    bidx;
      logic [31:0]   btgt;
      logic          stall;
      logic          busy;
      logic          ovf;
      logic [CW-1:0] bc;
      logic [CW-1:0] mc;
   } out_t;

   typedef struct {
      string name;
      bit    pre_rst;
      in_t   in;
      out_t  exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          Reset = 1'b1;
   logic          Branch_EX = 1'b0;
   logic          branchTaken = 1'b0;
   logic          prediction_EX = 1'b0;
   logic [31:0]   predicted_target_EX = '0;
   logic [31:0]   branch_target_EX = '0;
   logic [31:0]   PC_EX = '0;
   logic [4:0]    GHR_in = '0;
   logic [4:0]    GHPT_index_in = '0;
   logic [4:0]    G_BTB_index_in = '0;
   logic          flush, redirect_valid, ghr_restore_valid, pht_we, pht_taken, btb_we;
   logic [31:0]   redirect_PC, btb_target;
   logic [4:0]    ghr_restore, pht_index, btb_index;
   logic          stall_fetch, busy, overflow;
   logic [CW-1:0] branch_count, mispredict_count;

   out_t act;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t vecs[$];

   branch_recovery_controller #(.CNT_W(CW)) dut (
      .clk(clk), .Reset(Reset), .Branch_EX(Branch_EX), .branchTaken(branchTaken),
      .prediction_EX(prediction_EX), .predicted_target_EX(predicted_target_EX),
      .branch_target_EX(branch_target_EX), .PC_EX(PC_EX), .GHR_in(GHR_in),
      .GHPT_index_in(GHPT_index_in), .G_BTB_index_in(G_BTB_index_in),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_PC(redirect_PC),
      .ghr_restore_valid(ghr_restore_valid), .ghr_restore(ghr_restore),
      .pht_we(pht_we), .pht_index(pht_index), .pht_taken(pht_taken),
      .btb_we(btb_we), .btb_index(btb_index), .btb_target(btb_target),
      .stall_fetch(stall_fetch), .busy(busy), .overflow(overflow),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   assign act = {flush, redirect_valid, redirect_PC, ghr_restore_valid, ghr_restore,
                 pht_we, pht_index, pht_taken, btb_we, btb_index, btb_target,
                 stall_fetch, busy, overflow, branch_count, mispredict_count};

   function automatic in_t B(bit taken, bit pred, logic [31:0] ptgt, logic [31:0] tgt,
                             logic [31:0] pc, logic [4:0] ghr, logic [4:0] pi, logic [4:0] bi);
      in_t i;
      i.br = 1'b1; i.taken = taken; i.pred = pred; i.ptgt = ptgt; i.tgt = tgt;
      i.pc = pc; i.ghr = ghr; i.pi = pi; i.bi = bi;
      return i;
   endfunction

   function automatic in_t NB();
      in_t i = '0;
      return i;
   endfunction

   function automatic out_t e_idle(int bc, int mc, bit ov);
      out_t o = '0;
      o.bc = CW'(bc); o.mc = CW'(mc); o.ovf = ov;
      return o;
   endfunction

   function automatic out_t e_rec(logic [31:0] rpc, logic [4:0] gr, int bc, int mc, bit ov);
      out_t o = e_idle(bc, mc, ov);
      o.flush = 1'b1; o.rv = 1'b1; o.rpc = rpc; o.grv = 1'b1; o.gr = gr; o.busy = 1'b1;
      return o;
   endfunction

   function automatic out_t e_pht(logic [4:0] pidx, bit pt, int bc, int mc, bit ov);
      out_t o = e_idle(bc, mc, ov);
      o.pwe = 1'b1; o.pidx = pidx; o.pt = pt; o.stall = 1'b1; o.busy = 1'b1;
      return o;
   endfunction

   function automatic out_t e_btb(logic [4:0] bidx, logic [31:0] btgt, int bc, int mc, bit ov);
      out_t o = e_idle(bc, mc, ov);
      o.bwe = 1'b1; o.bidx = bidx; o.btgt = btgt; o.stall = 1'b1; o.busy = 1'b1;
      return o;
   endfunction

   // data fields are only meaningful while their strobe is high
   function automatic out_t norm(out_t o);
      out_t n = o;
      if (!n.rv)  n.rpc = '0;
      if (!n.grv) n.gr = '0;
      if (!n.pwe) begin n.pidx = '0; n.pt = 1'b0; end
      if (!n.bwe) begin n.bidx = '0; n.btgt = '0; end
      return n;
   endfunction

   function automatic void add(string n, bit r, in_t i, out_t e);
      vec_t v;
      v.name = n; v.pre_rst = r; v.in = i; v.exp = e;
      vecs.push_back(v);
   endfunction

   task automatic drive(input in_t i);
      Branch_EX = i.br; branchTaken = i.taken; prediction_EX = i.pred;
      predicted_target_EX = i.ptgt; branch_target_EX = i.tgt; PC_EX = i.pc;
      GHR_in = i.ghr; GHPT_index_in = i.pi; G_BTB_index_in = i.bi;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input out_t exp, input bit raw);
      out_t a;
      a = raw ? act : norm(act);
      n_vec++;
      if (a !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, a, exp);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      drive(NB());
      tick();
      Reset = 1'b0;
   endtask

   initial begin
      add("nt_pht",    0, B(0,0,32'h0,  32'h0,  32'h40, 5'h00, 5'h0A, 5'h00), e_pht(5'h0A,0,1,0,0));
      add("nt_idle",   0, NB(),                                                e_idle(1,0,0));
      add("dir_rec",   1, B(1,0,32'h0,  32'h200,32'h100,5'b10110,5'h03,5'h07), e_rec(32'h200,5'b01101,1,1,0));
      add("dir_pht",   0, NB(),                                                e_pht(5'h03,1,1,1,0));
      add("dir_btb",   0, NB(),                                                e_btb(5'h07,32'h200,1,1,0));
      add("dir_idle",  0, NB(),                                                e_idle(1,1,0));
      add("tgt_rec",   0, B(1,1,32'h300,32'h340,32'h500,5'b00001,5'h01,5'h02), e_rec(32'h340,5'b00011,2,2,0));
      add("tgt_pht",   0, NB(),                                                e_pht(5'h01,1,2,2,0));
      add("tgt_btb",   0, NB(),                                                e_btb(5'h02,32'h340,2,2,0));
      add("tgt_idle",  0, NB(),                                                e_idle(2,2,0));
      add("wrap_rec",  0, B(0,1,32'h1234,32'h1234,32'hFFFF_FFFC,5'b11111,5'h04,5'h05), e_rec(32'h0,5'b11110,3,3,0));
      add("wrap_pht",  0, NB(),                                                e_pht(5'h04,0,3,3,0));
      add("wrap_idle", 0, NB(),                                                e_idle(3,3,0));
      add("buf_b1",    1, B(1,1,32'h800,32'h800,32'h700,5'h00,5'h08,5'h09),   e_pht(5'h08,1,1,0,0));
      add("buf_b2",    0, B(1,1,32'h900,32'h900,32'h880,5'h00,5'h0A,5'h0B),   e_btb(5'h09,32'h800,2,0,0));
      add("buf_drop",  0, B(1,1,32'hA00,32'hA00,32'h980,5'h00,5'h0C,5'h0D),   e_idle(2,0,1));
      add("buf_pht2",  0, NB(),                                                e_pht(5'h0A,1,2,0,1));
      add("buf_btb2",  0, NB(),                                                e_btb(5'h0B,32'h900,2,0,1));
      add("buf_idle",  0, NB(),                                                e_idle(2,0,1));
      add("sq_rec",    1, B(1,0,32'h0,  32'h200,32'h100,5'h00,5'h02,5'h03),   e_rec(32'h200,5'b00001,1,1,0));
      add("sq_young",  0, B(0,0,32'h0,  32'h0,  32'h104,5'h00,5'h14,5'h15),   e_pht(5'h02,1,1,1,0));
      add("sq_btb",    0, NB(),                                                e_btb(5'h03,32'h200,1,1,0));
      add("sq_idle",   0, NB(),                                                e_idle(1,1,0));
      add("sq_quiet",  0, NB(),                                                e_idle(1,1,0));
      add("pq_g1",     1, B(0,0,32'h0,32'h0,32'h10,5'h00,5'h01,5'h00),        e_pht(5'h01,0,1,0,0));
      add("pq_g2",     0, B(0,0,32'h0,32'h0,32'h14,5'h00,5'h02,5'h00),        e_idle(2,0,0));
      add("pq_g3",     0, B(0,0,32'h0,32'h0,32'h18,5'h00,5'h03,5'h00),        e_pht(5'h02,0,3,0,0));
      add("pq_g4",     0, NB(),                                                e_idle(3,0,0));
      add("pq_g5",     0, NB(),                                                e_pht(5'h03,0,3,0,0));
      add("pq_g6",     0, NB(),                                                e_idle(3,0,0));

      drive(NB());
      tick();
      check("reset_state", '0, 1);
      Reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].pre_rst) do_reset();
         drive(vecs[i].in);
         tick();
         check(vecs[i].name, vecs[i].exp, 0);
      end

      // counters saturate at all-ones
      do_reset();
      for (int k = 0; k < 9; k++) begin
         drive(B(0,1,32'h0,32'h0,32'h1000 + 32'(k*4),5'h00,5'h00,5'h00));
         tick();
         drive(NB());
         tick();
         tick();
      end
      check("count_sat", e_idle(7,7,0), 0);

      // asynchronous reset while UPD_PHT is active
      do_reset();
      drive(B(1,0,32'h0,32'h200,32'h100,5'h00,5'h06,5'h07));
      tick();
      check("mid_rec", e_rec(32'h200,5'b00001,1,1,0), 0);
      drive(NB());
      tick();
      check("mid_pht", e_pht(5'h06,1,1,1,0), 0);
      #1 Reset = 1'b1;
      #1 check("async_reset", '0, 1);
      #1 Reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_reset_quiet", '0, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
